// File: rtl/idp_pkg.sv
// idp_pkg: shared definitions for the idp_sequencer slice -- element state
// codes, pathfunction codes, the sequencer FSM type and the bit-counter width.
package idp_pkg;

    // Element state codes presented on state_o
    localparam logic [1:0] STOP_ST = 2'b00;
    localparam logic [1:0] COST_ST = 2'b01;
    localparam logic [1:0] ROOT_ST = 2'b10;
    localparam logic [1:0] SAVE_ST = 2'b11;

    // Pathfunction codes: additive (C8L16) and max (C16L8)
    localparam logic C8L16 = 1'b0;
    localparam logic C16L8 = 1'b1;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        SCOST = 3'd2,
        SROOT = 3'd3,
        SSAVE = 3'd4,
        RESP  = 3'd5
    } seq_state_e;

    // Width of the shared bit counter: clog2 of the longest serial phase
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/idp_shift_lsb.sv
// idp_shift_lsb: parameterised load / shift-right register. Bits leave at
// bit 0 and shift_in_i enters at the MSB. OUT_W selects how many low bits
// are exposed (1 for a serialiser, W for a deserialiser).
module idp_shift_lsb
    import idp_pkg::*;
#(
    parameter int W     = 8,
    parameter int OUT_W = W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic             shift_i,
    input  logic             shift_in_i,
    output logic [OUT_W-1:0] data_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Load has priority over shift; otherwise hold
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (shift_i) begin
            data_d = {shift_in_i, data_q[W-1:1]};
        end
    end

    // Register with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q[OUT_W-1:0];

endmodule

// File: rtl/idp_sequencer.sv
// idp_sequencer: host-side driver for one bit-serial IFT path-cost element.
// Serialises a candidate record LSB-first through STOP->COST->ROOT->SAVE and
// deserialises the returned result stream into a parallel response word.
// Optional build macro IDP_SEQ_STATS_EN adds a saturating conquest counter.
//
// Handshakes: a request transfers on a cycle where req_valid_i && req_ready_o;
// a response transfers on a cycle where rsp_valid_o && rsp_ready_i. Response
// word/flag are held stable while rsp_valid_o is high and not yet accepted.
module idp_sequencer
    import idp_pkg::*;
#(
    parameter int COST_W = 8,
    parameter int ROOT_W = 16,
    parameter int RES_W  = 8,
    parameter int PATHFN = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [COST_W-1:0] ext_cost_i,
    input  logic [COST_W-1:0] int_cost_i,
    input  logic [ROOT_W-1:0] ext_root_i,
    input  logic [ROOT_W-1:0] int_root_i,
    input  logic              dir_i,
    output logic              pathfunction_o,
    output logic [1:0]        state_o,
    output logic              direction_o,
    output logic              extern_data_o,
    output logic [1:0]        intern_data_o,
    output logic              root_carry_in_o,
    input  logic              result_data_i,
    input  logic              conquest_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [RES_W-1:0]  rsp_word_o,
    output logic              rsp_conquest_o
`ifdef IDP_SEQ_STATS_EN
    ,
    input  logic              stats_clr_i,
    output logic [15:0]       conquest_cnt_o
`endif
);

    localparam int CNT_W = cnt_width(COST_W, ROOT_W, RES_W);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic             ext_q, ext_d;
    logic [1:0]       int_q, int_d;
    logic             dir_q, dir_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             conq_q, conq_d;

    logic             accept;
    logic             ext_cost_b, int_cost_b, ext_root_b, int_root_b;
    logic             cost_shift, root_shift, res_shift;
    logic [RES_W-1:0] rsp_word;

    assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    // A bit leaves a serialiser on the edge where its phase is being entered
    // or continued, so it lands in the output flop with its state code.
    assign cost_shift = (state_d == SCOST);
    assign root_shift = (state_d == SROOT);
    assign res_shift  = (state_q == SSAVE);

    idp_shift_lsb #(.W(COST_W), .OUT_W(1)) u_ext_cost (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(accept), .load_val_i(ext_cost_i),
        .shift_i(cost_shift), .shift_in_i(1'b0), .data_o(ext_cost_b)
    );

    idp_shift_lsb #(.W(COST_W), .OUT_W(1)) u_int_cost (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(accept), .load_val_i(int_cost_i),
        .shift_i(cost_shift), .shift_in_i(1'b0), .data_o(int_cost_b)
    );

    idp_shift_lsb #(.W(ROOT_W), .OUT_W(1)) u_ext_root (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(accept), .load_val_i(ext_root_i),
        .shift_i(root_shift), .shift_in_i(1'b0), .data_o(ext_root_b)
    );

    idp_shift_lsb #(.W(ROOT_W), .OUT_W(1)) u_int_root (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(accept), .load_val_i(int_root_i),
        .shift_i(root_shift), .shift_in_i(1'b0), .data_o(int_root_b)
    );

    // Result deserialiser: first received bit ends up in bit 0
    idp_shift_lsb #(.W(RES_W), .OUT_W(RES_W)) u_rsp_word (
        .clk_i(clk_i), .rst_i(rst_i), .load_i(1'b0), .load_val_i('0),
        .shift_i(res_shift), .shift_in_i(result_data_i), .data_o(rsp_word)
    );

    // Next-state and shared bit counter; counter reloads at every phase edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRIME;
                    cnt_d   = '0;
                end
            end
            PRIME: begin
                state_d = SCOST;
                cnt_d   = '0;
            end
            SCOST: begin
                if (cnt_q == CNT_W'(COST_W - 1)) begin
                    state_d = SROOT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SROOT: begin
                if (cnt_q == CNT_W'(ROOT_W - 1)) begin
                    state_d = SSAVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SSAVE: begin
                if (cnt_q == CNT_W'(RES_W - 1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = accept ? PRIME : IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Element-facing lines are computed from the state being entered
    always_comb begin
        code_d = STOP_ST;
        ext_d  = 1'b0;
        int_d  = 2'b00;
        case (state_d)
            PRIME: begin
                int_d = 2'b11;  // seed c1=c2=1 for two's-complement subtract
            end
            SCOST: begin
                code_d = COST_ST;
                ext_d  = ext_cost_b;
                int_d  = {2{int_cost_b}};
            end
            SROOT: begin
                code_d = ROOT_ST;
                ext_d  = ext_root_b;
                int_d  = {2{int_root_b}};
            end
            SSAVE: begin
                code_d = SAVE_ST;
            end
            default: ;
        endcase
        dir_d       = accept ? dir_i : dir_q;
        rsp_valid_d = (state_d == RESP);
        conq_d      = ((state_q == SSAVE) && (cnt_q == '0)) ? conquest_i : conq_q;
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_q      <= STOP_ST;
            ext_q       <= 1'b0;
            int_q       <= 2'b00;
            dir_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            conq_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            ext_q       <= ext_d;
            int_q       <= int_d;
            dir_q       <= dir_d;
            rsp_valid_q <= rsp_valid_d;
            conq_q      <= conq_d;
        end
    end

    assign pathfunction_o  = (PATHFN != 0) ? C16L8 : C8L16;
    assign state_o         = code_q;
    assign direction_o     = dir_q;
    assign extern_data_o   = ext_q;
    assign intern_data_o   = int_q;
    assign root_carry_in_o = 1'b0;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_word_o      = rsp_word;
    assign rsp_conquest_o  = conq_q;

`ifdef IDP_SEQ_STATS_EN
    logic [15:0] conq_cnt_q, conq_cnt_d;

    // Count conquering responses at handoff; saturate; clear beats increment
    always_comb begin
        conq_cnt_d = conq_cnt_q;
        if (stats_clr_i) begin
            conq_cnt_d = '0;
        end else if (rsp_valid_q && rsp_ready_i && conq_q && (conq_cnt_q != 16'hFFFF)) begin
            conq_cnt_d = conq_cnt_q + 16'd1;
        end
    end

    // Conquest counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conq_cnt_q <= '0;
        end else begin
            conq_cnt_q <= conq_cnt_d;
        end
    end

    assign conquest_cnt_o = conq_cnt_q;
`endif

endmodule

// File: tb/tb_idp_sequencer.sv
// tb_idp_sequencer: directed and randomised transactions against idp_sequencer,
// compared each cycle with a reference built from the serial-phase rules.
// Stats checks are compiled in when IDP_SEQ_STATS_EN is defined.
module tb_idp_sequencer;

    localparam int COST_W = 8;
    localparam int ROOT_W = 16;
    localparam int RES_W  = 8;
    localparam int PATHFN = 0;
    localparam int LAT    = 2 + COST_W + ROOT_W + RES_W;

    logic              clk;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [COST_W-1:0] ext_cost_i;
    logic [COST_W-1:0] int_cost_i;
    logic [ROOT_W-1:0] ext_root_i;
    logic [ROOT_W-1:0] int_root_i;
    logic              dir_i;
    logic              pathfunction_o;
    logic [1:0]        state_o;
    logic              direction_o;
    logic              extern_data_o;
    logic [1:0]        intern_data_o;
    logic              root_carry_in_o;
    logic              result_data_i;
    logic              conquest_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [RES_W-1:0]  rsp_word_o;
    logic              rsp_conquest_o;
`ifdef IDP_SEQ_STATS_EN
    logic              stats_clr_i;
    logic [15:0]       conquest_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    idp_sequencer #(
        .COST_W(COST_W), .ROOT_W(ROOT_W), .RES_W(RES_W), .PATHFN(PATHFN)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .ext_cost_i(ext_cost_i),
        .int_cost_i(int_cost_i),
        .ext_root_i(ext_root_i),
        .int_root_i(int_root_i),
        .dir_i(dir_i),
        .pathfunction_o(pathfunction_o),
        .state_o(state_o),
        .direction_o(direction_o),
        .extern_data_o(extern_data_o),
        .intern_data_o(intern_data_o),
        .root_carry_in_o(root_carry_in_o),
        .result_data_i(result_data_i),
        .conquest_i(conquest_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_word_o(rsp_word_o),
        .rsp_conquest_o(rsp_conquest_o)
`ifdef IDP_SEQ_STATS_EN
        ,
        .stats_clr_i(stats_clr_i),
        .conquest_cnt_o(conquest_cnt_o)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_clr(input logic v);
`ifdef IDP_SEQ_STATS_EN
        stats_clr_i = v;
`else
        if (v) $display("note: stats clear requested without stats build");
`endif
    endtask

    // Reference: {state code, extern bit, intern pair} in cycle c after accept
    function automatic logic [4:0] model_lines(input int c,
                                               input logic [COST_W-1:0] ec,
                                               input logic [COST_W-1:0] ic,
                                               input logic [ROOT_W-1:0] er,
                                               input logic [ROOT_W-1:0] ir);
        int k;
        if (c == 1) return {2'b00, 1'b0, 2'b11};
        k = c - 2;
        if (k < COST_W) return {2'b01, ec[k], ic[k], ic[k]};
        k = k - COST_W;
        if (k < ROOT_W) return {2'b10, er[k], ir[k], ir[k]};
        k = k - ROOT_W;
        if (k < RES_W) return 5'b11000;
        return 5'b00000;
    endfunction

    // One full transaction starting in the current (negedge) cycle.
    // b2b leaves the response handshake pending with a new request offered.
    task automatic txn(input logic [COST_W-1:0] ec, input logic [COST_W-1:0] ic,
                       input logic [ROOT_W-1:0] er, input logic [ROOT_W-1:0] ir,
                       input logic d, input logic [RES_W-1:0] res, input logic conq,
                       input int hold, input logic b2b, input logic clr);
        int k;
        ext_cost_i = ec; int_cost_i = ic; ext_root_i = er; int_root_i = ir; dir_i = d;
        req_valid_i = 1'b1;
        #1;
        check("req_ready_at_accept", req_ready_o, 1);
        @(negedge clk);
        set_clr(1'b0);
        for (int c = 1; c < LAT; c++) begin
            check($sformatf("lines_c%0d", c), {state_o, extern_data_o, intern_data_o},
                  model_lines(c, ec, ic, er, ir));
            check($sformatf("busy_c%0d", c), {req_ready_o, rsp_valid_o}, 2'b00);
            // unrelated request traffic must be ignored mid-sequence
            req_valid_i = 1'($urandom_range(0, 1));
            ext_cost_i  = COST_W'($urandom);
            int_cost_i  = COST_W'($urandom);
            ext_root_i  = ROOT_W'($urandom);
            int_root_i  = ROOT_W'($urandom);
            dir_i       = 1'($urandom_range(0, 1));
            rsp_ready_i = 1'($urandom_range(0, 1));
            if (c >= 2 + COST_W + ROOT_W) begin
                k = c - (2 + COST_W + ROOT_W);
                result_data_i = res[k];
                conquest_i    = (k == 0) ? conq : 1'($urandom_range(0, 1));
            end else begin
                result_data_i = 1'($urandom_range(0, 1));
                conquest_i    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        #1;
        check("rsp_valid_at_latency", rsp_valid_o, 1);
        check("rsp_word", rsp_word_o, res);
        check("rsp_conquest", rsp_conquest_o, conq);
        check("direction", direction_o, d);
        check("resp_lines", {state_o, extern_data_o, intern_data_o, req_ready_o}, 0);
        for (int h = 0; h < hold; h++) begin
            req_valid_i   = 1'($urandom_range(0, 1));
            result_data_i = 1'($urandom_range(0, 1));
            conquest_i    = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            check("hold_stable", {rsp_valid_o, rsp_word_o, rsp_conquest_o, state_o, req_ready_o},
                  {1'b1, res, conq, 2'b00, 1'b0});
        end
        req_valid_i = b2b;
        rsp_ready_i = 1'b1;
        set_clr(clr);
        #1;
        check("req_ready_release", req_ready_o, 1);
        if (clr) exp_cnt = 0;
        else if (conq && exp_cnt < 65535) exp_cnt++;
        if (!b2b) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            rsp_ready_i = 1'b0;
            set_clr(1'b0);
            #1;
            check("idle_after_handshake", {rsp_valid_o, state_o, req_ready_o}, {1'b0, 2'b00, 1'b1});
`ifdef IDP_SEQ_STATS_EN
            check("conquest_cnt", conquest_cnt_o, exp_cnt);
`endif
        end
    endtask

    // Start a request, then reset asynchronously in cycle 15 (ROOT phase)
    task automatic reset_mid_root();
        ext_cost_i = 8'hFF; int_cost_i = 8'hFF; ext_root_i = 16'hFFFF; int_root_i = 16'hFFFF;
        dir_i = 1'b1;
        req_valid_i = 1'b1;
        #1;
        @(negedge clk);
        req_valid_i = 1'b0;
        for (int c = 1; c < 15; c++) @(negedge clk);
        check("state_mid_root", {state_o, extern_data_o, intern_data_o}, 5'b10111);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_reset_outputs",
              {state_o, extern_data_o, intern_data_o, direction_o, rsp_valid_o,
               rsp_word_o, rsp_conquest_o, root_carry_in_o}, 0);
        exp_cnt = 0;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("ready_after_mid_reset", {req_ready_o, state_o}, 3'b100);
    endtask

    // Directed steps
    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; ext_cost_i = '0; int_cost_i = '0; ext_root_i = '0; int_root_i = '0;
        dir_i = 1'b0; result_data_i = 1'b0; conquest_i = 1'b0; rsp_ready_i = 1'b0;
        set_clr(1'b0);
        repeat (3) @(negedge clk);
        check("reset_lines",
              {state_o, extern_data_o, intern_data_o, direction_o, rsp_valid_o,
               rsp_word_o, rsp_conquest_o, root_carry_in_o}, 0);
        rst_i = 1'b0;
        #1;
        check("ready_after_reset", req_ready_o, 1);
        check("pathfunction", pathfunction_o, PATHFN);
        @(negedge clk);

        // directed record with 10 cycles of response backpressure
        txn(8'h05, 8'h03, 16'h0001, 16'h0002, 1'b1, 8'h53, 1'b1, 10, 1'b0, 1'b0);
        // back-to-back pair
        txn(8'hA7, 8'h3C, 16'h1234, 16'hBEEF, 1'b0, 8'hC5, 1'b0, 2, 1'b1, 1'b0);
        txn(8'h81, 8'h7E, 16'h8001, 16'h7FFE, 1'b1, 8'h0F, 1'b1, 0, 1'b0, 1'b0);

        // asynchronous reset mid-ROOT, then a clean sequence
        reset_mid_root();
        txn(8'h05, 8'h03, 16'h0001, 16'h0002, 1'b1, 8'h53, 1'b1, 0, 1'b0, 1'b0);

        // randomised records, some back-to-back
        for (int t = 0; t < 6; t++) begin
            txn(COST_W'($urandom), COST_W'($urandom), ROOT_W'($urandom), ROOT_W'($urandom),
                1'($urandom_range(0, 1)), RES_W'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), (t < 5) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
        end

`ifdef IDP_SEQ_STATS_EN
        // clear coincident with an increment, then 3 conquests and 2 misses
        txn(8'h11, 8'h22, 16'h3333, 16'h4444, 1'b0, 8'hAA, 1'b1, 0, 1'b0, 1'b1);
        txn(8'h01, 8'h02, 16'h0003, 16'h0004, 1'b0, 8'h01, 1'b1, 0, 1'b0, 1'b0);
        txn(8'h05, 8'h06, 16'h0007, 16'h0008, 1'b1, 8'h02, 1'b0, 1, 1'b0, 1'b0);
        txn(8'h09, 8'h0A, 16'h000B, 16'h000C, 1'b0, 8'h03, 1'b1, 0, 1'b0, 1'b0);
        txn(8'h0D, 8'h0E, 16'h000F, 16'h0010, 1'b1, 8'h04, 1'b0, 0, 1'b0, 1'b0);
        txn(8'h11, 8'h12, 16'h0013, 16'h0014, 1'b0, 8'h05, 1'b1, 2, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idp_sequencer.md
Name: idp_sequencer

Overview:
- Host-side driver for the bit-serial IFT path-cost element.
- Accepts one parallel candidate record per request: external and internal cost, external and internal root, direction.
- Serialises the record LSB-first onto the element's state/data lines through the STOP→COST→ROOT→SAVE sequence.
- Deserialises the returned result_data stream and conquest flag into a parallel response word.
- Sits between the sector's node-fetch logic and one processing element.

Parameters:
- COST_W, 8, cost field width in bits (serial COST phase length).
- ROOT_W, 16, root label width in bits (serial ROOT phase length).
- RES_W, 8, width of the response word captured during SAVE.
- PATHFN, 0, pathfunction value driven to the element (0 = additive, 1 = max).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- ext_cost_i  in  COST_W  external (neighbour) cost
- int_cost_i  in  COST_W  internal (current) cost
- ext_root_i  in  ROOT_W  external root label
- int_root_i  in  ROOT_W  internal root label
- dir_i  in  1  direction bit
- pathfunction_o  out  1  constant PATHFN
- state_o  out  2  element state code
- direction_o  out  1  registered dir_i
- extern_data_o  out  1  serial external bit
- intern_data_o  out  2  serial internal bits
- root_carry_in_o  out  1  carry injection, 0 in base build
- result_data_i  in  1  serial result from element
- conquest_i  in  1  element conquest flag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted when valid&ready
- rsp_word_o  out  RES_W  deserialised result, LSB received first
- rsp_conquest_o  out  1  conquest sampled for this request

Behaviour:
- State codes: STOP=2'b00, COST=2'b01, ROOT=2'b10, SAVE=2'b11.
- FSM states and state_o values:
  - IDLE: STOP.
  - PRIME: STOP, 1 cycle.
  - SCOST: COST, COST_W cycles.
  - SROOT: ROOT, ROOT_W cycles.
  - SSAVE: SAVE, RES_W cycles.
  - RESP: STOP.
- Accept: req_valid_i&req_ready_o latches all request fields into shift registers and moves IDLE→PRIME.
- req_ready_o=1 in IDLE, and in RESP when rsp_ready_i=1 (back-to-back handshake; the next request goes to PRIME directly).
- PRIME: intern_data_o=2'b11 (seeds element carries c1=c2=1 for two's-complement subtract); extern_data_o=0.
- SCOST, bit k = cycle index 0..COST_W-1:
  - extern_data_o = ext_cost[k].
  - intern_data_o = {int_cost[k], int_cost[k]}.
- SROOT, bit k:
  - extern_data_o = ext_root[k].
  - intern_data_o = {int_root[k], int_root[k]}.
- SSAVE: extern_data_o=0, intern_data_o=0.
  - rsp_word shifts right, result_data_i entering the MSB. After RES_W cycles, bit 0 holds the first received bit.
  - rsp_conquest is sampled from conquest_i in the first SSAVE cycle.
- All serial outputs are registered; a bit is presented the cycle its state code is presented.
- A single bit counter is shared across phases: it reloads at each phase boundary and terminates at width-1. No phase ever runs a short or extra cycle.
- Latency: accept at cycle 0 → rsp_valid_o=1 at cycle 2+COST_W+ROOT_W+RES_W (34 with defaults).
- RESP: rsp_valid_o and rsp_word_o are held stable until rsp_ready_i. Exit to IDLE, or to PRIME when a new request is accepted in the same cycle.
- req_valid_i is ignored outside the ready windows; request inputs are not sampled mid-sequence.
- Reset values, any cycle including mid-sequence:
  - FSM = IDLE, state_o = STOP.
  - All data outputs 0, rsp_valid_o = 0, rsp_word_o = 0, rsp_conquest_o = 0.
  - req_ready_o = 1 after reset deasserts.
- root_carry_in_o = 0 always in the base build.

Optional Feature:
- Macro IDP_SEQ_STATS_EN.
- Defined:
  - Adds output conquest_cnt_o [15:0]. It increments on each response handshake with rsp_conquest_o=1, saturates at 16'hFFFF, and clears on reset.
  - Adds input stats_clr_i, a synchronous clear; clear wins over a simultaneous increment.
- Undefined: ports and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package idp_pkg:
  - State-code localparams STOP_ST/COST_ST/ROOT_ST/SAVE_ST.
  - Pathfunction codes C8L16/C16L8.
  - FSM state enum type.
  - Function for the counter width, clog2 of max(COST_W, ROOT_W, RES_W).
- One natural sub-module, idp_shift_lsb: a parameterised load/shift-right register used for the four serialisers and the deserialiser.

Test Plan:
- Reset, then one request: ext_cost=8'h05, int_cost=8'h03, ext_root=16'h0001, int_root=16'h0002, dir=1 → state_o is 00 for 1 cycle, 01 for 8, 10 for 16, 11 for 8; extern_data_o in COST reads 1,0,1,0,0,0,0,0; rsp_valid_o rises at cycle 34.
- Deserialise: drive result_data_i = 1,1,0,0,1,0,1,0 during SAVE with conquest_i=1 → rsp_word_o=8'h53, rsp_conquest_o=1.
- Backpressure: hold rsp_ready_i=0 for 10 cycles → rsp_word_o stable, req_ready_o=0, state_o=STOP; release → accepted in 1 cycle.
- Back-to-back: req_valid_i=1 with rsp_ready_i=1 in RESP → PRIME in the next cycle, no IDLE bubble, second response at +34 cycles after the handshake.
- Reset mid-ROOT (cycle 15): all outputs return to reset values asynchronously; the next request completes normally with the correct stream.
- IDP_SEQ_STATS_EN: 3 responses with conquest=1 and 2 with conquest=0 → conquest_cnt_o=3; stats_clr_i coincident with an increment → 0.
